// File: rtl/cordic_divider_approx_2u6_pkg.sv
// Shared Q-format constants, saturation codes and controller states for the
// linear-vectoring CORDIC divider.
package cordic_divider_approx_2u6_pkg;

    localparam int Q_FRAC_BITS = 8;
    localparam int Q_RES_SHIFT = 6;

    localparam logic [15:0] Q_SAT_POS = 16'h7FFF;
    localparam logic [15:0] Q_SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // 9-bit magnitude so that |-128| = 128 is representable.
    function automatic logic [8:0] mag9(input logic [7:0] v);
        logic [8:0] ext;
        ext = {v[7], v};
        return v[7] ? (9'd0 - ext) : ext;
    endfunction

endpackage

// File: rtl/add16se_2U6.sv
// Approximate 16-bit sign-extended adder: the two low bits are OR-ed and
// their carry is dropped, so the result is low by (a & b)[1:0] at most.
module add16se_2U6 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [16:0] o
);
    logic [14:0] hi_sum;

    assign hi_sum = {a[15], a[15:2]} + {b[15], b[15:2]};
    assign o[16:2] = hi_sum;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_low
            assign o[gi] = a[gi] | b[gi];
        end
    endgenerate

endmodule

// File: rtl/cordic_div_residual_step.sv
// One residual update r +/- (d >>> i): picks the direction from the signs
// of r and d, using the approximate adder pair or an exact add/sub.
module cordic_div_residual_step #(
    parameter int APPROX = 1
) (
    input  logic signed [15:0] r,
    input  logic signed [15:0] s,
    input  logic               d_neg,
    output logic signed [15:0] r_next,
    output logic               dir_sub
);
    logic signed [15:0] r_add;
    logic signed [15:0] r_sub;

    // r == 0 has sign bit 0, so it counts as positive here.
    assign dir_sub = (r[15] == d_neg);

    generate
        if (APPROX != 0) begin : g_approx
            logic [16:0] sum_add;
            logic [16:0] sum_sub;
            logic [15:0] neg_s;
            logic        unused_carry;

            assign neg_s = -s;

            add16se_2U6 u_add (
                .a (r),
                .b (s),
                .o (sum_add)
            );

            add16se_2U6 u_sub (
                .a (r),
                .b (neg_s),
                .o (sum_sub)
            );

            assign r_add        = sum_add[15:0];
            assign r_sub        = sum_sub[15:0];
            assign unused_carry = sum_add[16] ^ sum_sub[16];
        end else begin : g_exact
            assign r_add = r + s;
            assign r_sub = r - s;
        end
    endgenerate

    assign r_next = dir_sub ? r_sub : r_add;

endmodule

// File: rtl/cordic_divider_approx_2u6.sv
// Sequential linear-vectoring CORDIC divider: q = y / x in Q7.8, one
// iteration per clock, with start/busy/done handshake and error saturation.
module cordic_divider_approx_2u6
    import cordic_divider_approx_2u6_pkg::*;
#(
    parameter int ITERATIONS = 9,
    parameter int FRAC_BITS  = Q_FRAC_BITS,
    parameter int RES_SHIFT  = Q_RES_SHIFT,
    parameter int APPROX     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  y,
    input  logic [7:0]  x,
    output logic [15:0] q,
    output logic        busy,
    output logic        done,
    output logic        dz_err,
    output logic        range_err
);
    localparam int I_W = $clog2(ITERATIONS + 1);

    state_t             state_reg;
    logic signed [15:0] r_reg;
    logic signed [15:0] d_reg;
    logic [I_W-1:0]     i_reg;
    logic [15:0]        q_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               dz_reg;
    logic               range_reg;

    logic signed [15:0] s_shift;
    logic signed [15:0] r_next;
    logic               dir_sub;
    logic [15:0]        step_w;
    logic [15:0]        y_ext;
    logic [15:0]        x_ext;
    logic               x_zero;
    logic               mag_over;
    logic               op_err;
    logic [15:0]        q_sat;

    assign s_shift = d_reg >>> i_reg;
    assign step_w  = 16'(32'd1 << (FRAC_BITS - int'(i_reg)));

    assign y_ext = {{8{y[7]}}, y} << RES_SHIFT;
    assign x_ext = {{8{x[7]}}, x} << RES_SHIFT;

    // With x == 0 the magnitude test is trivially true; dz takes precedence.
    assign x_zero   = (x == 8'd0);
    assign mag_over = ({1'b0, mag9(y)} >= {mag9(x), 1'b0});
    assign op_err   = x_zero | mag_over;
    assign q_sat    = (y[7] == x[7]) ? Q_SAT_POS : Q_SAT_NEG;

    cordic_div_residual_step #(
        .APPROX (APPROX)
    ) u_step (
        .r       (r_reg),
        .s       (s_shift),
        .d_neg   (d_reg[15]),
        .r_next  (r_next),
        .dir_sub (dir_sub)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            r_reg     <= '0;
            d_reg     <= '0;
            i_reg     <= '0;
            q_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dz_reg    <= 1'b0;
            range_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        busy_reg <= 1'b1;
                        i_reg    <= '0;
                        if (op_err) begin
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                            q_reg     <= q_sat;
                            dz_reg    <= x_zero;
                            range_reg <= !x_zero;
                        end else begin
                            state_reg <= RUN;
                            r_reg     <= y_ext;
                            d_reg     <= x_ext;
                            q_reg     <= '0;
                            dz_reg    <= 1'b0;
                            range_reg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_reg <= r_next;
                    q_reg <= dir_sub ? (q_reg + step_w) : (q_reg - step_w);
                    i_reg <= i_reg + 1'b1;
                    if (i_reg == I_W'(ITERATIONS - 1)) begin
                        state_reg <= FIN;
                        done_reg  <= 1'b1;
                    end
                end
                FIN: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign q         = q_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign dz_err    = dz_reg;
    assign range_err = range_reg;

endmodule
